// File: rtl/mont_mul_pipe.sv
// Three-stage Montgomery multiplier: res = a*b*2^-W mod q, one result per cycle.
// q and qprime ride along with each operation so the modulus may change per beat.
module mont_mul_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] op0_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] qprime_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int W = DATA_WIDTH;

  // Final conditional subtraction; u == q must map to 0, hence >=.
  function automatic logic [W-1:0] cond_sub(input logic [W:0] u, input logic [W-1:0] q);
    if (u >= {1'b0, q}) return W'(u - {1'b0, q});
    return W'(u);
  endfunction

  logic           en_p0, en_p1, en_p2;
  logic           vld_p0, vld_p1, vld_p2;
  logic [2*W-1:0] t_p0, t_p1;
  logic [W-1:0]   q_p0, qp_p0;
  logic [W-1:0]   m_p1, q_p1;
  logic [W-1:0]   res_p2;

  logic [2*W-1:0] prod_s1;
  logic [W-1:0]   m_s2;
  logic [2*W-1:0] mq_s3;
  logic [2*W:0]   sum_s3;
  logic [W:0]     u_s3;

  // Backpressure ripples from the output; a stage moves when it is empty or its successor moves.
  assign en_p2      = ~vld_p2 | out_ready_i;
  assign en_p1      = ~vld_p1 | en_p2;
  assign en_p0      = ~vld_p0 | en_p1;
  assign in_ready_o = en_p0;

  assign prod_s1 = {{W{1'b0}}, op0_i} * {{W{1'b0}}, op1_i};
  assign m_s2    = t_p0[W-1:0] * qp_p0;
  assign mq_s3   = {{W{1'b0}}, m_p1} * {{W{1'b0}}, q_p1};
  assign sum_s3  = {1'b0, t_p1} + {1'b0, mq_s3};
  assign u_s3    = (W+1)'(sum_s3 >> W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      t_p0   <= '0;
      q_p0   <= '0;
      qp_p0  <= '0;
      t_p1   <= '0;
      m_p1   <= '0;
      q_p1   <= '0;
      res_p2 <= '0;
    end else begin
      // stage p0: full-width product
      if (en_p0) begin
        vld_p0 <= in_valid_i;
        t_p0   <= prod_s1;
        q_p0   <= q_i;
        qp_p0  <= qprime_i;
      end
      // stage p1: Montgomery quotient m
      if (en_p1) begin
        vld_p1 <= vld_p0;
        t_p1   <= t_p0;
        m_p1   <= m_s2;
        q_p1   <= q_p0;
      end
      // stage p2: reduction and final subtraction
      if (en_p2) begin
        vld_p2 <= vld_p1;
        res_p2 <= cond_sub(u_s3, q_p1);
      end
      if (flush_i) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end
    end
  end

  assign out_valid_o = vld_p2;
  assign res_o       = res_p2;

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Directed and scoreboarded checks of mont_mul_pipe with q = 8380417, W = 32.
module tb_mont_mul_pipe;

  localparam logic [31:0] Q  = 32'd8380417;
  localparam logic [31:0] QP = 32'd4236238847;
  localparam logic [31:0] RM = 32'd4193792;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op0 = '0;
  logic [31:0] op1 = '0;
  logic [31:0] q = Q;
  logic [31:0] qprime = QP;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;
  int n_out = 0;
  int n0 = 0;
  logic mon_on = 1'b0;
  logic [31:0] sb[$];
  logic prev_stall = 1'b0;
  logic prev_flush = 1'b0;
  logic [31:0] prev_res = '0;

  mont_mul_pipe #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op0_i(op0), .op1_i(op1), .q_i(q), .qprime_i(qprime),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: reduce a*b mod q, then halve mod q 32 times.
  function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x;
    x = (64'(a) * 64'(b)) % 64'(Q);
    for (int i = 0; i < 32; i++) x = x[0] ? (x + 64'(Q)) >> 1 : x >> 1;
    return x[31:0];
  endfunction

  function automatic logic [31:0] rnd_op();
    return 32'($urandom_range(32'(Q - 1), 0));
  endfunction

  // The low word of t + m*q must vanish whenever stage p1 holds an operation.
  always @(negedge clk) begin : redc_chk
    logic [64:0] s;
    if (!rst && dut.vld_p1) begin
      s = {1'b0, dut.t_p1} + 65'(dut.m_p1) * 65'(dut.q_p1);
      check("redc_low", 64'(s[31:0]), 64'd0);
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (mon_on) begin
      check("in_ready", 64'(in_ready), 64'(!(sb.size() == 3 && !out_ready)));
      if (prev_stall && !prev_flush) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_res", 64'(res), 64'(prev_res));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else begin
          e = sb.pop_front();
          check("stream_res", 64'(res), 64'(e));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(mont_ref(op0, op1));
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_res   = res;
    end else begin
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end
  end

  task automatic one_shot(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    @(posedge clk); #1;
    op0 = a; op1 = b; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk); check({tag, "_lat2"}, 64'(out_valid), 64'd0);
    @(negedge clk); check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'(res), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    mon_on = 1'b1;

    one_shot("rm_12345", RM, 32'd12345, 32'd12345);
    one_shot("rm_qm1", RM, Q - 1, Q - 1);
    one_shot("zero_a", 32'd0, Q - 1, 32'd0);
    one_shot("zero_b", RM, 32'd0, 32'd0);
    one_shot("rm_sq", RM, RM, RM);
    one_shot("u_eq_q", Q, 32'd1, 32'd0);

    // back-to-back stream
    @(negedge clk);
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op0 = rnd_op(); op1 = rnd_op(); out_ready = 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stream_count", 64'(n_out - n0), 64'd100);

    // random valid / backpressure
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(1, 0)); op0 = rnd_op(); op1 = rnd_op();
      out_ready = 1'($urandom_range(1, 0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("drain_valid", 64'(out_valid), 64'd0);

    // flush with the pipeline full and stalled
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op0 = rnd_op(); op1 = rnd_op(); out_ready = 1'b0;
    end
    @(posedge clk); #1;
    op0 = rnd_op(); op1 = rnd_op(); flush = 1'b1;
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    check("full_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("flush_quiet", 64'(out_valid), 64'd0);
    end

    // flush colliding with an accepted operand
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op0 = rnd_op(); op1 = rnd_op(); out_ready = 1'b0;
    end
    @(posedge clk); #1;
    op0 = RM; op1 = 32'd99; flush = 1'b1;
    check("flush2_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("flush2_quiet", 64'(out_valid), 64'd0);
    end
    one_shot("post_flush", RM, 32'd5, 32'd5);

    // out-of-contract operands must still flow through
    @(posedge clk); #1;
    mon_on = 1'b0;
    op0 = '1; op1 = '1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 6 && !out_valid; k++) @(negedge clk);
    check("ooc_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    mon_on = 1'b1;
    one_shot("post_ooc", RM, 32'd12345, 32'd12345);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op0 = rnd_op(); op1 = rnd_op(); out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 mon_on = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_res", 64'(res), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    sb.delete();
    mon_on = 1'b1;
    one_shot("post_rst", RM, 32'd7, 32'd7);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_mul_pipe.md
Name: mont_mul_pipe

Overview:
- Pipelined Montgomery modular multiplier for the PQ vector datapath.
- Computes res = a·b·R⁻¹ mod q, with R = 2^DATA_WIDTH.
- Sits directly downstream of the modular subtractor in the Gentleman-Sande butterfly: it takes the (a−b) mod q difference and multiplies it by the twiddle factor.
- Fully pipelined: throughput 1 result/cycle, valid/ready handshake on both sides, so it can stall against the vector writeback.

Parameters:
- DATA_WIDTH, 32, operand/modulus width W; R = 2^W.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous pipeline clear; all valid bits dropped next cycle.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block accepts operands this cycle.
- op0_i  input  W  multiplicand a, required a < q.
- op1_i  input  W  multiplier b (twiddle), required b < q.
- q_i  input  W  modulus; odd, q < 2^(W-1).
- qprime_i  input  W  −q⁻¹ mod R.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- res_o  output  W  a·b·R⁻¹ mod q, always in [0, q).

Behaviour:
- Stages are registered, each with its own valid bit v1, v2, v3. q and qprime travel with the data in each stage, so the modulus may change per operation.
- S1 (input accept): t = op0_i·op1_i as a full 2W-bit product; register t, q, qprime.
- S2: m = (t[W-1:0]·qprime) mod R, keeping the low W bits only; register t, m, q.
- S3: u = (t + m·q) >> W, computed in 2W+1 bits so the carry is kept. u < 2q, and u is held in W+1 bits.
  - Output u−q if u ≥ q, otherwise u.
  - Register into res_o.
  - The low W bits of t + m·q must be zero; this is an assertion in the bench.
- Latency: 3 cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, when there is no backpressure.
- Stage enable:
  - en3 = ~v3 | out_ready_i
  - en2 = ~v2 | en3
  - en1 = ~v1 | en2
- Handshake:
  - in_ready_o = en1. It is combinational from out_ready_i through the valid bits; no combinational path from in_valid_i to in_ready_o.
  - When enN is high, stage N loads from the previous stage, including its valid bit. When enN is low, stage N holds its data and valid bit.
  - While out_valid_o=1 and out_ready_i=0: res_o and out_valid_o stay stable.
  - Pipeline bubbles collapse under backpressure. Full occupancy is 3 outstanding operations.
- out_valid_o = v3. res_o is the S3 data register.
- flush_i:
  - Clears v1, v2, v3 on the next edge. Data registers are don't-care.
  - flush_i dominates a simultaneous input accept: the accepted operand is discarded.
  - in_ready_o is unaffected by flush_i.
- Reset (rst_i asserted, including mid-operation):
  - Immediately: v1, v2, v3 = 0, out_valid_o = 0, res_o = 0.
  - All data registers are cleared to 0.
  - in_ready_o = 1 while in reset and after reset.
- Boundary values:
  - a = 0 or b = 0 gives 0.
  - u == q exactly gives 0, never q.
  - Operands ≥ q are outside the contract; the result is unspecified but must not hang the pipeline.

Test Plan (W=32, q=8380417, qprime=4236238847, R mod q=4193792):
- a=4193792, b=12345, out_ready_i=1 → res_o=12345 with out_valid_o high exactly 3 cycles after accept.
- a=4193792, b=8380416 → 8380416; a=0, b=8380416 → 0; a=4193792, b=4193792 → 4193792.
- Back-to-back stream of 100 random a, b < q, out_ready_i=1 → one result per cycle, in order, each matching a golden model of a·b·2⁻³² mod q. in_ready_o stays 1 throughout.
- Random out_ready_i (50%) with random in_valid_i → no drops or duplicates, res_o stable while stalled. in_ready_o=0 only when all 3 stages are valid and out_ready_i=0.
- Fill 3 entries with out_ready_i=0, then pulse flush_i together with in_valid_i → out_valid_o=0 next cycle; no result from the flushed or same-cycle operands ever appears.
- Assert rst_i asynchronously mid-stream, between clock edges → out_valid_o and res_o drop to 0 before the next edge. After release, a fresh a=4193792, b=7 yields 7 after 3 cycles.
